// File: rtl/alu_16.sv
// -----------------------------------------------------------------------------
// alu_16 : 16-bit ALU with a single stored-carry register (Cs).
//
// The result and the N/Z/C/V flags are purely combinational from the operands,
// the opcode and Cs. Cs is the only state: it captures the combinational C
// output on every rising clock edge while a defined opcode is applied, and it
// holds while an undefined opcode (0x13-0xFF) is applied. This lets ADC/SBC and
// ROL/ROR chain across cycles.
//
// Ports:
//   clock        in   1   rising-edge clock for the stored-carry register
//   reset        in   1   asynchronous active-high reset, clears Cs
//   ALU_data_in1 in  16   operand A
//   ALU_data_in2 in  16   operand B
//   ALU_control  in   8   opcode
//   ALU_data_out out 16   result
//   N            out  1   negative flag (result[15])
//   Z            out  1   zero flag (result == 0)
//   C            out  1   carry flag
//   V            out  1   signed-overflow flag
// -----------------------------------------------------------------------------
module alu_16 (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ALU_data_in1,
  input  logic [15:0] ALU_data_in2,
  input  logic [7:0]  ALU_control,
  output logic [15:0] ALU_data_out,
  output logic        N,
  output logic        Z,
  output logic        C,
  output logic        V
);

  localparam logic [7:0] OP_AND  = 8'h00;
  localparam logic [7:0] OP_OR   = 8'h01;
  localparam logic [7:0] OP_XOR  = 8'h02;
  localparam logic [7:0] OP_NOT  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h04;
  localparam logic [7:0] OP_ADC  = 8'h05;
  localparam logic [7:0] OP_SUB  = 8'h06;
  localparam logic [7:0] OP_SBC  = 8'h07;
  localparam logic [7:0] OP_INC  = 8'h08;
  localparam logic [7:0] OP_DEC  = 8'h09;
  localparam logic [7:0] OP_LSL1 = 8'h0A;
  localparam logic [7:0] OP_LSR1 = 8'h0B;
  localparam logic [7:0] OP_ASR1 = 8'h0C;
  localparam logic [7:0] OP_ROL  = 8'h0D;
  localparam logic [7:0] OP_ROR  = 8'h0E;
  localparam logic [7:0] OP_MOV  = 8'h0F;
  localparam logic [7:0] OP_LSLN = 8'h10;
  localparam logic [7:0] OP_LSRN = 8'h11;
  localparam logic [7:0] OP_ASRN = 8'h12;

  logic        cs_q;
  logic        cs_d;

  logic [15:0] a;
  logic [15:0] b;
  assign a = ALU_data_in1;
  assign b = ALU_data_in2;

  // ---------------------------------------------------------------------------
  // Shared adder. Subtract-type ops feed ~B (DEC feeds ~1) so that C is the
  // carry out of A+~B+cin, i.e. 1 means "no borrow".
  // ---------------------------------------------------------------------------
  logic [15:0] add_b;
  logic        add_cin;
  logic [16:0] add_sum;
  logic        add_v;

  always_comb begin
    add_b   = b;
    add_cin = 1'b0;
    case (ALU_control)
      OP_ADD:  begin add_b = b;        add_cin = 1'b0; end
      OP_ADC:  begin add_b = b;        add_cin = cs_q; end
      OP_SUB:  begin add_b = ~b;       add_cin = 1'b1; end
      OP_SBC:  begin add_b = ~b;       add_cin = cs_q; end
      OP_INC:  begin add_b = 16'h0001; add_cin = 1'b0; end
      OP_DEC:  begin add_b = 16'hFFFE; add_cin = 1'b1; end
      default: begin add_b = b;        add_cin = 1'b0; end
    endcase
  end

  assign add_sum = {1'b0, a} + {1'b0, add_b} + {16'h0000, add_cin};

  // With the (possibly inverted) second operand, one rule covers both add and
  // subtract overflow: operands agree in sign but the result does not.
  assign add_v = (a[15] == add_b[15]) && (add_sum[15] != a[15]);

  // ---------------------------------------------------------------------------
  // Barrel shifts. A guard bit carries the last bit shifted out; with an
  // amount of 0 the guard bit stays 0, which gives C=0 for free.
  // ---------------------------------------------------------------------------
  logic [3:0]  sh_amt;
  logic [16:0] lsl_ext;
  logic [16:0] lsr_ext;
  logic [16:0] asr_ext;

  assign sh_amt  = b[3:0];
  assign lsl_ext = {1'b0, a} << sh_amt;
  assign lsr_ext = {a, 1'b0} >> sh_amt;
  assign asr_ext = $signed({a, 1'b0}) >>> sh_amt;

  // ---------------------------------------------------------------------------
  // Result / flag selection
  // ---------------------------------------------------------------------------
  logic [15:0] res;
  logic        c_out;
  logic        v_out;
  logic        op_defined;

  always_comb begin
    res        = 16'h0000;
    c_out      = 1'b0;
    v_out      = 1'b0;
    op_defined = 1'b1;
    case (ALU_control)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NOT:  res = ~a;
      OP_MOV:  res = b;
      OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_INC, OP_DEC: begin
        res   = add_sum[15:0];
        c_out = add_sum[16];
        v_out = add_v;
      end
      OP_LSL1: begin res = {a[14:0], 1'b0};  c_out = a[15]; end
      OP_LSR1: begin res = {1'b0, a[15:1]};  c_out = a[0];  end
      OP_ASR1: begin res = {a[15], a[15:1]}; c_out = a[0];  end
      OP_ROL:  begin res = {a[14:0], cs_q};  c_out = a[15]; end
      OP_ROR:  begin res = {cs_q, a[15:1]};  c_out = a[0];  end
      OP_LSLN: begin res = lsl_ext[15:0];    c_out = lsl_ext[16]; end
      OP_LSRN: begin res = lsr_ext[16:1];    c_out = lsr_ext[0];  end
      OP_ASRN: begin res = asr_ext[16:1];    c_out = asr_ext[0];  end
      default: op_defined = 1'b0;
    endcase
  end

  assign ALU_data_out = res;
  assign N            = res[15];
  assign Z            = (res == 16'h0000);
  assign C            = c_out;
  assign V            = v_out;

  // ---------------------------------------------------------------------------
  // Stored carry
  // ---------------------------------------------------------------------------
  assign cs_d = op_defined ? c_out : cs_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_q <= 1'b0;
    end else begin
      cs_q <= cs_d;
    end
  end

endmodule

// File: tb/tb_alu_16.sv
// -----------------------------------------------------------------------------
// tb_alu_16 : directed, table-driven bench for alu_16.
// Each table entry fixes the stored carry beforehand, applies one opcode,
// checks result and flags, clocks once and checks the stored carry after.
// The stored carry is observed through ROL with A=0 (result = {15'b0, Cs}).
// -----------------------------------------------------------------------------
module tb_alu_16;

  logic        clock;
  logic        reset;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic [7:0]  op_in;
  logic [15:0] out;
  logic        n_f, z_f, c_f, v_f;

  int checks = 0;
  int errors = 0;

  alu_16 dut (
    .clock        (clock),
    .reset        (reset),
    .ALU_data_in1 (a_in),
    .ALU_data_in2 (b_in),
    .ALU_control  (op_in),
    .ALU_data_out (out),
    .N            (n_f),
    .Z            (z_f),
    .C            (c_f),
    .V            (v_f)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cs;     // stored carry before the vector
    logic [15:0] out;
    logic [3:0]  nzcv;
    logic        cs_after;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cs, input logic [15:0] o, input logic [3:0] nzcv,
                         input logic cs_after);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.cs = cs; v.out = o; v.nzcv = nzcv; v.cs_after = cs_after;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    op_in = op; a_in = a; b_in = b;
  endtask

  // Result is {15'b0, Cs}; no clock edge happens between drive and sample.
  task automatic probe_cs(input string name, input int idx, input logic exp);
    drive(8'h0D, 16'h0000, 16'h0000);
    #1;
    chk(name, idx, out, {15'h0000, exp});
  endtask

  task automatic set_cs(input logic v);
    @(negedge clock);
    if (v) begin
      drive(8'h04, 16'hFFFF, 16'h0001);
      @(posedge clock);
      #1;
    end else begin
      drive(8'hFF, 16'h0000, 16'h0000);
      reset = 1'b1;
      #1;
      reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(8'h0D, 16'h0000, 16'h0000);

    //        op     A        B        Cs  out      NZCV     Cs'
    add_vec(8'h00, 16'h8007, 16'hC005, 0, 16'h8005, 4'b1000, 0);
    add_vec(8'h01, 16'h00F0, 16'h0F00, 1, 16'h0FF0, 4'b0000, 0);
    add_vec(8'h02, 16'hFFFF, 16'h00FF, 1, 16'hFF00, 4'b1000, 0);
    add_vec(8'h03, 16'h1234, 16'h0000, 1, 16'hEDCB, 4'b1000, 0);
    add_vec(8'h04, 16'h7FFF, 16'h0001, 0, 16'h8000, 4'b1001, 0);
    add_vec(8'h04, 16'hFFFF, 16'h0001, 0, 16'h0000, 4'b0110, 1);
    add_vec(8'h05, 16'h0001, 16'h0001, 1, 16'h0003, 4'b0000, 0);
    add_vec(8'h06, 16'h0005, 16'h0005, 0, 16'h0000, 4'b0110, 1);
    add_vec(8'h06, 16'h0003, 16'h0005, 1, 16'hFFFE, 4'b1000, 0);
    add_vec(8'h06, 16'h8000, 16'h0001, 0, 16'h7FFF, 4'b0011, 1);
    add_vec(8'h07, 16'h0005, 16'h0003, 0, 16'h0001, 4'b0010, 1);
    add_vec(8'h07, 16'h8000, 16'h0001, 1, 16'h7FFF, 4'b0011, 1);
    add_vec(8'h08, 16'hFFFF, 16'h0000, 0, 16'h0000, 4'b0110, 1);
    add_vec(8'h08, 16'h7FFF, 16'h0000, 1, 16'h8000, 4'b1001, 0);
    add_vec(8'h09, 16'h0000, 16'h0000, 1, 16'hFFFF, 4'b1000, 0);
    add_vec(8'h09, 16'h8000, 16'h0000, 0, 16'h7FFF, 4'b0011, 1);
    add_vec(8'h0A, 16'h8001, 16'h0000, 0, 16'h0002, 4'b0010, 1);
    add_vec(8'h0B, 16'h8001, 16'h0000, 0, 16'h4000, 4'b0010, 1);
    add_vec(8'h0C, 16'h8001, 16'h0000, 0, 16'hC000, 4'b1010, 1);
    add_vec(8'h0D, 16'h8000, 16'h0000, 1, 16'h0001, 4'b0010, 1);
    add_vec(8'h0E, 16'h0001, 16'h0000, 0, 16'h0000, 4'b0110, 1);
    add_vec(8'h0E, 16'h0002, 16'h0000, 1, 16'h8001, 4'b1000, 0);
    add_vec(8'h0F, 16'h1234, 16'h8000, 1, 16'h8000, 4'b1000, 0);
    add_vec(8'h10, 16'hF00F, 16'hFFF4, 0, 16'h00F0, 4'b0010, 1);
    add_vec(8'h10, 16'h0001, 16'h000F, 1, 16'h8000, 4'b1000, 0);
    add_vec(8'h11, 16'h8001, 16'h0010, 1, 16'h8001, 4'b1000, 0);
    add_vec(8'h11, 16'h8001, 16'h000F, 1, 16'h0001, 4'b0000, 0);
    add_vec(8'h12, 16'h8004, 16'h0002, 1, 16'hE001, 4'b1000, 0);
    add_vec(8'h12, 16'h8000, 16'h000F, 0, 16'hFFFF, 4'b1000, 0);
    add_vec(8'hE6, 16'h000A, 16'h000C, 1, 16'h0000, 4'b0100, 1);
    add_vec(8'h13, 16'hFFFF, 16'hFFFF, 0, 16'h0000, 4'b0100, 0);
    add_vec(8'hFF, 16'h8000, 16'h8000, 1, 16'h0000, 4'b0100, 1);

    // reset state: Cs=0 seen through ROL, undefined opcode output
    #2;
    chk("reset_cs", 0, out, 16'h0000);
    drive(8'hE6, 16'h000A, 16'h000C);
    #1;
    chk("reset_undef", 0, {out[15:4], n_f, z_f, c_f, v_f}, 16'h0004);
    @(negedge clock);
    reset = 1'b0;

    foreach (vq[i]) begin
      set_cs(vq[i].cs);
      @(negedge clock);
      drive(vq[i].op, vq[i].a, vq[i].b);
      #1;
      chk("out", i, out, vq[i].out);
      chk("nzcv", i, {12'h000, n_f, z_f, c_f, v_f}, {12'h000, vq[i].nzcv});
      @(posedge clock);
      #1;
      probe_cs("cs_after", i, vq[i].cs_after);
    end

    // stored carry chain: ADD FFFF+1, edge, ADC 1+1 -> 3
    @(negedge clock);
    drive(8'h04, 16'hFFFF, 16'h0001);
    @(posedge clock);
    #1;
    @(negedge clock);
    drive(8'h05, 16'h0001, 16'h0001);
    #1;
    chk("adc_chain", 0, out, 16'h0003);

    // same with a reset pulse before the ADC -> 2
    @(negedge clock);
    drive(8'h04, 16'hFFFF, 16'h0001);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(negedge clock);
    drive(8'h05, 16'h0001, 16'h0001);
    #1;
    chk("adc_after_rst", 0, out, 16'h0002);

    // reset held across a clock edge keeps Cs=0; outputs follow Cs=0
    @(negedge clock);
    reset = 1'b1;
    drive(8'h04, 16'hFFFF, 16'h0001);
    #1;
    chk("add_in_rst_c", 0, {15'h0000, c_f}, 16'h0001);
    @(posedge clock);
    #1;
    drive(8'h05, 16'h0001, 16'h0001);
    #1;
    chk("adc_in_rst", 0, out, 16'h0002);
    probe_cs("cs_in_rst", 0, 1'b0);

    // first edge after release loads normally
    @(negedge clock);
    reset = 1'b0;
    drive(8'h04, 16'hFFFF, 16'h0001);
    @(posedge clock);
    #1;
    probe_cs("cs_first_edge", 0, 1'b1);

    // asynchronous clear with no clock edge
    set_cs(1'b1);
    @(negedge clock);
    drive(8'h05, 16'h0001, 16'h0001);
    #1;
    chk("adc_cs1", 0, out, 16'h0003);
    reset = 1'b1;
    #1;
    chk("async_clr", 0, out, 16'h0002);
    #1;
    reset = 1'b0;

    // undefined opcode held over several edges keeps Cs=1
    set_cs(1'b1);
    @(negedge clock);
    drive(8'h80, 16'h1234, 16'h5678);
    repeat (3) @(posedge clock);
    #1;
    probe_cs("cs_hold_undef", 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // time limit
  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
